channel_sequencer: RTL and testbench
====================================

CHANNEL_SEQUENCER -- requirements
Module: channel_sequencer

Interface
REQ-001 The block SHALL have parameter DWELL_CYCLES, default 16: cycles each channel is held in auto mode, legal range 2..255.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port enable, input, 1 bit: run request; 0 holds or returns the block to IDLE.
REQ-005 The block SHALL have port auto_mode, input, 1 bit: 1 = timed advance, 0 = manual advance on next_req.
REQ-006 The block SHALL have port next_req, input, 1 bit: manual advance request, rising-edge detected internally.
REQ-007 The block SHALL have port fault, input, 1 bit: level fault indication from the tank sensors.
REQ-008 The block SHALL have port fault_clr, input, 1 bit: operator acknowledge that leaves ERROR.
REQ-009 The block SHALL have port select, output, 5 bits: channel code driven to the downstream 7-way 8-bit mux.
REQ-010 The block SHALL have port chan_idx, output, 3 bits: current channel number 0..5, or 7 in ERROR.
REQ-011 The block SHALL have port sel_valid, output, 1 bit: 1 when select addresses a live sensor channel.
REQ-012 The block SHALL have port err_mode, output, 1 bit: 1 while in ERROR.
REQ-013 The block SHALL have port fault_cnt, output, 8 bits: fault entry count, per REQ-031.

Function
REQ-014 Channel codes SHALL be: ch0=00000, ch1=00001, ch2=00010, ch3=00100, ch4=01000, ch5=10000, error=11111; no other value is ever driven.
REQ-015 The FSM SHALL have exactly three states: IDLE, SCAN, ERROR.
REQ-016 All outputs SHALL be registered, one-cycle latency from the sampled input to the output change.
REQ-017 IDLE: select=00000, chan_idx=0, sel_valid=0, err_mode=0; enable=1 -> SCAN on the next edge, at ch0 with the dwell counter at 0.
REQ-018 SCAN: sel_valid=1; in auto mode the 8-bit dwell counter counts 0..DWELL_CYCLES-1, and at terminal count the channel advances and the counter clears.
REQ-019 Channel advance SHALL wrap ch5 -> ch0.
REQ-020 In SCAN with auto_mode=0, the counter SHALL hold at 0 and the channel advances by exactly one per next_req rising edge; a held-high next_req gives one advance.
REQ-021 A next_req edge coinciding with an auto terminal count SHALL produce a single advance.
REQ-022 A change of auto_mode SHALL clear the dwell counter without changing the channel.
REQ-023 SCAN with enable=0 -> IDLE on the next edge.
REQ-024 fault=1 in any state SHALL force ERROR on the next edge, with priority over enable, next_req and terminal count.
REQ-025 ERROR: select=11111, chan_idx=7, sel_valid=0, err_mode=1; the state is sticky.
REQ-026 ERROR exits to IDLE only when fault_clr=1 and fault=0 are sampled together; fault_clr while fault=1 is ignored.
REQ-027 fault_clr outside ERROR SHALL have no effect.

Reset
REQ-028 rst_n=0 SHALL immediately, without waiting for a clock edge, force IDLE: select=00000, chan_idx=0, sel_valid=0, err_mode=0, dwell counter 0, next_req edge register 0, fault_cnt 0.
REQ-029 Reset asserted mid-SCAN or mid-ERROR SHALL discard the channel position and latched error; after release, operation restarts from IDLE per REQ-017.
REQ-030 Reset release SHALL be taken on the first clock edge after rst_n=1, with no extra wait cycles.

Configuration
REQ-031 Macro SEQ_FAULT_COUNT_EN: when defined, fault_cnt increments by 1 on each IDLE/SCAN -> ERROR transition, saturates at 255 and is cleared only by reset; when undefined, fault_cnt is tied to 8'h00 and no counter logic exists.

Verification
REQ-032 Reset then enable=1, auto_mode=1, DWELL_CYCLES=4 -> select steps 00000,00001,00010,00100,01000,10000,00000 every 4 cycles, with sel_valid=1 throughout.
REQ-033 auto_mode=0, next_req held high 10 cycles, then low, then pulsed twice -> exactly three advances: ch0 -> ch3.
REQ-034 fault=1 for one cycle mid-SCAN at ch2 -> next cycle select=11111, err_mode=1, chan_idx=7; fault_clr with fault=1 -> stays ERROR; fault=0 with fault_clr=1 -> IDLE, select=00000.
REQ-035 rst_n low asynchronously between clock edges during ERROR -> outputs at IDLE values before the next edge.
REQ-036 With SEQ_FAULT_COUNT_EN, 300 fault/clear cycles -> fault_cnt=255; without the macro -> fault_cnt=0.

Source files
------------

// File: rtl/channel_sequencer.sv
// ============================================================================
// Module   : channel_sequencer
// Purpose  : Steps a 7-way sensor mux through six channels, either on a
//            timed dwell or on manual requests, with a sticky ERROR state.
// Option   : SEQ_FAULT_COUNT_EN enables the saturating fault entry counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module channel_sequencer #(
    parameter int DWELL_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       auto_mode,
    input  logic       next_req,
    input  logic       fault,
    input  logic       fault_clr,
    output logic [4:0] select,
    output logic [2:0] chan_idx,
    output logic       sel_valid,
    output logic       err_mode,
    output logic [7:0] fault_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_ERROR = 2'd2
    } state_t;

    localparam logic [7:0] C_DWELL_LAST = 8'(DWELL_CYCLES - 1);
    localparam logic [2:0] C_LAST_CHAN  = 3'd5;
    localparam logic [4:0] C_ERR_CODE   = 5'b11111;
    localparam logic [2:0] C_ERR_IDX    = 3'd7;

    state_t     state_q, state_d;
    logic [2:0] chan_q, chan_d;
    logic [7:0] cnt_q, cnt_d;
    logic       next_q;
    logic       auto_q;
    logic [4:0] select_q;
    logic [2:0] chan_idx_q;
    logic       sel_valid_q;
    logic       err_mode_q;

    logic       w_rise;
    logic       w_mode_chg;
    logic       w_tc;
    logic [2:0] w_chan_inc;

    // Channel 0 is the all-zero code; channels 1..5 are one-hot.
    function automatic logic [4:0] chan_code(input logic [2:0] ch);
        logic [4:0] code;
        code = 5'b00000;
        case (ch)
            3'd1:    code = 5'b00001;
            3'd2:    code = 5'b00010;
            3'd3:    code = 5'b00100;
            3'd4:    code = 5'b01000;
            3'd5:    code = 5'b10000;
            default: code = 5'b00000;
        endcase
        return code;
    endfunction

    assign w_rise     = next_req & ~next_q;
    assign w_mode_chg = auto_mode ^ auto_q;
    assign w_tc       = (cnt_q == C_DWELL_LAST);
    assign w_chan_inc = (chan_q == C_LAST_CHAN) ? 3'd0 : chan_q + 3'd1;

    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                chan_d = 3'd0;
                cnt_d  = 8'd0;
                if (fault) begin
                    state_d = S_ERROR;
                end else if (enable) begin
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (fault) begin
                    state_d = S_ERROR;
                    chan_d  = 3'd0;
                    cnt_d   = 8'd0;
                end else if (!enable) begin
                    state_d = S_IDLE;
                    chan_d  = 3'd0;
                    cnt_d   = 8'd0;
                end else if (w_mode_chg) begin
                    // A mode switch restarts the dwell and suppresses any advance.
                    cnt_d = 8'd0;
                end else if (auto_mode) begin
                    if (w_tc) begin
                        cnt_d  = 8'd0;
                        chan_d = w_chan_inc;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else begin
                    cnt_d = 8'd0;
                    if (w_rise) begin
                        chan_d = w_chan_inc;
                    end
                end
            end
            S_ERROR: begin
                chan_d = 3'd0;
                cnt_d  = 8'd0;
                if (fault_clr && !fault) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                chan_d  = 3'd0;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            chan_q      <= 3'd0;
            cnt_q       <= 8'd0;
            next_q      <= 1'b0;
            auto_q      <= 1'b0;
            select_q    <= 5'b00000;
            chan_idx_q  <= 3'd0;
            sel_valid_q <= 1'b0;
            err_mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            cnt_q   <= cnt_d;
            next_q  <= next_req;
            auto_q  <= auto_mode;
            case (state_d)
                S_SCAN: begin
                    select_q    <= chan_code(chan_d);
                    chan_idx_q  <= chan_d;
                    sel_valid_q <= 1'b1;
                    err_mode_q  <= 1'b0;
                end
                S_ERROR: begin
                    select_q    <= C_ERR_CODE;
                    chan_idx_q  <= C_ERR_IDX;
                    sel_valid_q <= 1'b0;
                    err_mode_q  <= 1'b1;
                end
                default: begin
                    select_q    <= 5'b00000;
                    chan_idx_q  <= 3'd0;
                    sel_valid_q <= 1'b0;
                    err_mode_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SEQ_FAULT_COUNT_EN
    logic [7:0] fault_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_cnt_q <= 8'd0;
        end else if ((state_q != S_ERROR) && fault && (fault_cnt_q != 8'hFF)) begin
            fault_cnt_q <= fault_cnt_q + 8'd1;
        end
    end

    assign fault_cnt = fault_cnt_q;
`else
    assign fault_cnt = 8'h00;
`endif

    assign select    = select_q;
    assign chan_idx  = chan_idx_q;
    assign sel_valid = sel_valid_q;
    assign err_mode  = err_mode_q;

endmodule

`default_nettype wire

// File: tb/tb_channel_sequencer.sv
// ============================================================================
// Module   : tb_channel_sequencer
// Purpose  : Self-checking bench for channel_sequencer against a rule model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_channel_sequencer;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       auto_mode = 1'b0;
    logic       next_req = 1'b0;
    logic       fault = 1'b0;
    logic       fault_clr = 1'b0;
    logic [4:0] select;
    logic [2:0] chan_idx;
    logic       sel_valid;
    logic       err_mode;
    logic [7:0] fault_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: 0 = idle, 1 = scanning, 2 = error
    int m_state, m_chan, m_cnt, m_fcnt;
    bit m_prev_next, m_prev_auto;
    logic [4:0] codes [6] = '{5'h00, 5'h01, 5'h02, 5'h04, 5'h08, 5'h10};

    always #5 clk = ~clk;

    channel_sequencer #(.DWELL_CYCLES(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .auto_mode (auto_mode),
        .next_req  (next_req),
        .fault     (fault),
        .fault_clr (fault_clr),
        .select    (select),
        .chan_idx  (chan_idx),
        .sel_valid (sel_valid),
        .err_mode  (err_mode),
        .fault_cnt (fault_cnt)
    );

    function void model_reset();
        m_state = 0; m_chan = 0; m_cnt = 0; m_fcnt = 0;
        m_prev_next = 1'b0; m_prev_auto = 1'b0;
    endfunction

    function void model_fault_entry();
        m_state = 2; m_chan = 0; m_cnt = 0;
`ifdef SEQ_FAULT_COUNT_EN
        if (m_fcnt < 255) m_fcnt++;
`endif
    endfunction

    function void model_step();
        bit rise, chg;
        rise = next_req && !m_prev_next;
        chg  = (auto_mode != m_prev_auto);
        if (m_state == 0) begin
            if (fault) model_fault_entry();
            else if (enable) begin m_state = 1; m_chan = 0; m_cnt = 0; end
        end else if (m_state == 1) begin
            if (fault) model_fault_entry();
            else if (!enable) begin m_state = 0; m_chan = 0; m_cnt = 0; end
            else if (chg) m_cnt = 0;
            else if (auto_mode) begin
                m_cnt++;
                if (m_cnt == D) begin m_cnt = 0; m_chan = (m_chan + 1) % 6; end
            end else if (rise) m_chan = (m_chan + 1) % 6;
        end else begin
            if (fault_clr && !fault) m_state = 0;
        end
        m_prev_next = next_req;
        m_prev_auto = auto_mode;
    endfunction

    function logic [17:0] exp_vec();
        logic [7:0] fc;
        fc = 8'(m_fcnt);
        if (m_state == 1) return {codes[m_chan], 3'(m_chan), 1'b1, 1'b0, fc};
        if (m_state == 2) return {5'b11111, 3'd7, 1'b0, 1'b1, fc};
        return {5'b00000, 3'd0, 1'b0, 1'b0, fc};
    endfunction

    function logic [17:0] act_vec();
        return {select, chan_idx, sel_valid, err_mode, fault_cnt};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        rst_n = 1'b0;
        #3;
        n_tests++;
        if (act_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_hold: got %h exp %h", act_vec(), exp_vec());
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_idle cyc %0d: got %h exp %h", i, act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_auto_scan();
        enable = 1'b1;
        auto_mode = 1'b1;
        for (int i = 1; i <= 28; i++) begin
            tick();
            n_tests++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL auto_scan cyc %0d: got %h exp %h", i, act_vec(), exp_vec());
            end
            n_tests++;
            if (select !== codes[((i - 1) / D) % 6] || sel_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL auto_seq cyc %0d: got sel=%b valid=%b exp sel=%b valid=1",
                         i, select, sel_valid, codes[((i - 1) / D) % 6]);
            end
        end
    endtask

    task automatic test_manual();
        enable = 1'b0;
        tick();
        enable = 1'b1;
        auto_mode = 1'b0;
        next_req = 1'b0;
        tick();
        for (int i = 0; i < 18; i++) begin
            if (i < 10)       next_req = 1'b1;
            else if (i < 12)  next_req = 1'b0;
            else              next_req = (i == 12 || i == 14) ? 1'b1 : 1'b0;
            tick();
            n_tests++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL manual cyc %0d: got %h exp %h", i, act_vec(), exp_vec());
            end
        end
        n_tests++;
        if (chan_idx !== 3'd3 || select !== 5'b00100) begin
            n_fail++;
            $display("FAIL manual_final: got idx=%0d sel=%b exp idx=3 sel=00100", chan_idx, select);
        end
    endtask

    task automatic test_fault();
        enable = 1'b0; next_req = 1'b0;
        tick();
        enable = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            next_req = (i % 2 == 0);
            tick();
        end
        n_tests++;
        if (chan_idx !== 3'd2) begin
            n_fail++;
            $display("FAIL fault_setup: got idx=%0d exp idx=2", chan_idx);
        end
        fault = 1'b1;
        tick();
        fault = 1'b0;
        n_tests++;
        if (select !== 5'b11111 || err_mode !== 1'b1 || chan_idx !== 3'd7 || sel_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fault_enter: got sel=%b err=%b idx=%0d exp 11111/1/7", select, err_mode, chan_idx);
        end
        repeat (2) tick();
        fault = 1'b1; fault_clr = 1'b1;
        tick();
        n_tests++;
        if (err_mode !== 1'b1 || act_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL fault_clr_ignored: got %h exp %h", act_vec(), exp_vec());
        end
        fault = 1'b0; enable = 1'b0;
        tick();
        fault_clr = 1'b0;
        n_tests++;
        if (select !== 5'b00000 || err_mode !== 1'b0 || act_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL fault_exit: got %h exp %h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_async_reset();
        enable = 1'b1; auto_mode = 1'b1;
        repeat (3) tick();
        fault = 1'b1;
        tick();
        fault = 1'b0;
        tick();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if (act_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL async_reset: got %h exp %h", act_vec(), exp_vec());
        end
        #1;
        rst_n = 1'b1;
        tick();
        n_tests++;
        if (act_vec() !== exp_vec() || sel_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: got %h exp %h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            fault     = ($urandom_range(0, 19) == 0);
            fault_clr = ($urandom_range(0, 3) == 0);
            enable    = ($urandom_range(0, 15) != 0);
            next_req  = $urandom_range(0, 1) != 0;
            if ($urandom_range(0, 29) == 0) auto_mode = ~auto_mode;
            tick();
            n_tests++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %h exp %h", i, act_vec(), exp_vec());
            end
        end
        fault = 1'b0; fault_clr = 1'b0; next_req = 1'b0;
    endtask

    task automatic test_fault_count();
        logic [7:0] sat;
`ifdef SEQ_FAULT_COUNT_EN
        sat = 8'd255;
`else
        sat = 8'd0;
`endif
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        rst_n = 1'b1;
        enable = 1'b0;
        for (int i = 0; i < 300; i++) begin
            fault = 1'b1; fault_clr = 1'b0;
            tick();
            fault = 1'b0; fault_clr = 1'b1;
            tick();
            if (i == 9 || i == 299) begin
                n_tests++;
                if (act_vec() !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL fault_cnt_run iter %0d: got %h exp %h", i, act_vec(), exp_vec());
                end
            end
        end
        fault_clr = 1'b0;
        n_tests++;
        if (fault_cnt !== sat) begin
            n_fail++;
            $display("FAIL fault_cnt_sat: got %0d exp %0d", fault_cnt, sat);
        end
    endtask

    initial begin
        test_reset();
        test_auto_scan();
        test_manual();
        test_fault();
        test_async_reset();
        test_random();
        test_fault_count();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
